apb_req_arbiter: RTL
====================

# apb_req_arbiter

Multi-requester APB master that shares a single APB target (the `apb_slave` data latch) between `NREQ` internal clients. It arbitrates round-robin and drives the APB setup/access phases. It waits on `pready` with a bounded timeout and returns read data or an error to the granted client. It sits between the core-side request ports and the APB target and is the only driver of that target's `psel`/`penable`/`pwrite`/`paddr`/`pwdata`/`p_strobe`.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `TIMEOUT`, 16: maximum ACCESS-phase cycles before the transfer is aborted (1..255).

Ports (one clock; reset is asynchronous and active-high):
- `pclk` in 1: clock, all state on rising edge.
- `preset` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: per-client request pending, held until accepted.
- `req_write` in NREQ: per-client 1 = write, 0 = read.
- `req_addr` in NREQ*32: per-client address, client i at [32i+31:32i].
- `req_wdata` in NREQ*32: per-client write data.
- `req_strobe` in NREQ*2: per-client byte-count code, 00 = 1 byte … 11 = 4 bytes.
- `req_ready` out NREQ: one-hot, one-cycle accept pulse.
- `rsp_valid` out NREQ: one-hot, one-cycle completion pulse to the owning client.
- `rsp_rdata` out 32: read data, valid with `rsp_valid`.
- `rsp_err` out 1: timeout flag, valid with `rsp_valid`.
- `u_busy` in 1: target busy; no new grant while high.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr`, `pwdata` out 32: APB address and write data.
- `p_strobe` out 2: byte-count code passed through from the granted client.
- `pready` in 1: APB ready.
- `prdata` in 32: APB read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any `req_valid` and `!u_busy`: grant the first requesting index at or after `rr_ptr` (wrapping), pulse `req_ready[g]` for that cycle, and latch `req_*[g]` into command registers.
  - Set `rr_ptr <= (g+1) mod NREQ` and go to SETUP.
  - `req_valid` with `u_busy` = 1: stay IDLE and issue no grant.
- SETUP: `psel=1`, `penable=0`, APB address/data/control from the command registers. Always exactly one cycle, then ACCESS.
- ACCESS:
  - `psel=1`, `penable=1`; `wait_cnt` increments each cycle.
  - `pready=1`: capture `prdata` (reads only; writes capture 0), `err=0`, go to RESP.
  - `wait_cnt == TIMEOUT-1` with `pready=0`: `err=1`, `rdata=0`, go to RESP.
  - `pready` wins when it coincides with the timeout cycle.
- RESP: `psel=0`, `penable=0`; drive `rsp_valid[g]`, `rsp_rdata`, `rsp_err` for one cycle, then IDLE. RESP plus IDLE guarantees ≥2 cycles with `penable` low between transfers so the target returns to its idle state.
- `req_valid` changes outside IDLE are ignored; a client is not regranted until its response has been issued.
- Width rules:
  - `wait_cnt` is `$clog2(TIMEOUT+1)` bits and is cleared on SETUP entry.
  - `rr_ptr` is `$clog2(NREQ)` bits and wraps at NREQ, including non-power-of-2 NREQ.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `rr_ptr=0`, command registers 0.
- `preset` mid-transfer drops `psel`/`penable` asynchronously and no `rsp_valid` is issued.
- Latency, with the grant at edge 0:
  - `psel` rises after edge 0.
  - `penable` rises after edge 1.
  - `pready` sampled high at edge k → `rsp_valid` high for the cycle after edge k.
- With the current `apb_slave` (registered `pready` two cycles after `penable`), a transfer is 6 cycles request-to-response and ≥7 cycles between grants.
- Timeout response: `rsp_valid` in the cycle after the TIMEOUT-th ACCESS cycle.
- `req_ready` and `rsp_valid` are registered, never combinational from inputs. APB outputs are registered and stable for the whole SETUP+ACCESS.

## Structure
- Package `apb_ctrl_pkg`: FSM state enum (IDLE/SETUP/ACCESS/RESP), strobe code constants (STRB_1B…STRB_4B), APB data/address width localparams.
- Sub-module `rr_arbiter`: parameter NREQ; inputs `req`, `ptr`; outputs one-hot `gnt` and binary `gnt_idx`; purely combinational.
- Top level holds the FSM, command registers, timeout counter and response registers.

## Test plan
- Single write: client 0 writes `paddr=0x10`, `pwdata=0xDEADBEEF`, strobe 11 → one SETUP cycle, then ACCESS until `pready`; `rsp_valid=01`, `rsp_err=0`; target latch reads back `0xDEADBEEF`.
- Read after write: client 1 reads with strobe 01 after the write above → `rsp_valid=10`, `rsp_rdata=0x0000BEEF`.
- Round-robin: NREQ=3, all `req_valid` held high for 3 transfers → grant order 0,1,2, then 0 again; no client granted twice in a row while others request.
- Timeout: `pready` tied 0, TIMEOUT=4 → `penable` high exactly 4 cycles, then `rsp_valid` with `rsp_err=1`, `rsp_rdata=0`.
- Busy hold-off: `u_busy=1` for 5 cycles with `req_valid=01` → no `req_ready`/`psel` until the cycle after `u_busy` falls.
- Reset mid-ACCESS: assert `preset` during ACCESS → `psel`/`penable` 0 immediately, no `rsp_valid`; after release, `rr_ptr=0` and the next request to client 0 is granted first.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the multi-requester APB master.
// Holds the FSM state encoding, strobe codes and APB bus widths.
package apb_ctrl_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    localparam logic [1:0] STRB_1B = 2'b00;
    localparam logic [1:0] STRB_2B = 2'b01;
    localparam logic [1:0] STRB_3B = 2'b10;
    localparam logic [1:0] STRB_4B = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping at NREQ (NREQ need not be a power of two).
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int IW = $clog2(NREQ);

    int   idx;
    logic found;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// APB master shared by NREQ clients: round-robin grant, SETUP/ACCESS phases,
// bounded wait on pready, and a one-cycle response to the granted client.
module apb_req_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_write,
    input  logic [NREQ*32-1:0]  req_addr,
    input  logic [NREQ*32-1:0]  req_wdata,
    input  logic [NREQ*2-1:0]   req_strobe,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    input  logic                u_busy,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [31:0]         paddr,
    output logic [31:0]         pwdata,
    output logic [1:0]          p_strobe,
    input  logic                pready,
    input  logic [31:0]         prdata
);

    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

    apb_state_e          state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       gnt_idx_q, gnt_idx_d;
    logic                cmd_write_q, cmd_write_d;
    logic [APB_AW-1:0]   cmd_addr_q, cmd_addr_d;
    logic [APB_DW-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [1:0]          cmd_strobe_q, cmd_strobe_d;
    logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [NREQ-1:0]     req_ready_q, req_ready_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [APB_DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [IW-1:0]       arb_idx;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_idx_d    = gnt_idx_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_strobe_d = cmd_strobe_q;
        wait_cnt_d   = wait_cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req_valid && !u_busy) begin
                    state_d      = SETUP;
                    req_ready_d  = arb_gnt;
                    gnt_idx_d    = arb_idx;
                    cmd_write_d  = req_write[arb_idx];
                    cmd_addr_d   = req_addr[int'(arb_idx)*APB_AW +: APB_AW];
                    cmd_wdata_d  = req_wdata[int'(arb_idx)*APB_DW +: APB_DW];
                    cmd_strobe_d = req_strobe[int'(arb_idx)*2 +: 2];
                    rr_ptr_d     = (arb_idx == LAST_IDX) ? '0 : arb_idx + IW'(1);
                    wait_cnt_d   = '0;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                wait_cnt_d = wait_cnt_q + WW'(1);
                // pready takes priority on the final allowed cycle.
                if (pready || wait_cnt_q == WAIT_LAST) begin
                    state_d                = RESP;
                    psel_d                 = 1'b0;
                    penable_d              = 1'b0;
                    rsp_valid_d[gnt_idx_q] = 1'b1;
                    rsp_err_d              = !pready;
                    rsp_rdata_d            = (pready && !cmd_write_q) ? prdata : '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_idx_q    <= '0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_strobe_q <= '0;
            wait_cnt_q   <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_strobe_q <= cmd_strobe_d;
            wait_cnt_q   <= wait_cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = cmd_write_q;
    assign paddr     = cmd_addr_q;
    assign pwdata    = cmd_wdata_q;
    assign p_strobe  = cmd_strobe_q;

endmodule
